// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I multi-cycle sequencer.
//   - RV32I major opcodes (IR[6:0])
//   - sequencer state enum (values are visible on the debug state port)
//   - pc_sel / wb_sel / alu_op select encodings
//   - is_legal_op(): the opcode set the sequencer accepts
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
      default:                           is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags a stall timeout.
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   clear    in  restart the count (state change)
//   count_en in  this cycle is a wait cycle (access pending, no mem_ready)
//   expired  out this wait cycle is number MEM_TIMEOUT; never set when
//                MEM_TIMEOUT == 0
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] SAT  = CW'(MEM_TIMEOUT);
  // cnt_q holds the number of earlier wait cycles, so the Nth wait sees N-1
  localparam logic [CW-1:0] LAST = (MEM_TIMEOUT < 1) ? '0 : CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = '0;
    else if (count_en && cnt_q != SAT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (MEM_TIMEOUT != 0) && count_en && (cnt_q >= LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB)
// over one shared variable-latency memory port.
//   clk, rst           clock, synchronous active-high reset
//   opcode             IR[6:0], valid from DECODE onward
//   mem_ready          current memory access completes this cycle
//   branch_taken       ALU branch condition, valid in EXEC
//   pc_we, pc_sel      PC load and next-PC source
//   ir_we              latch fetched word into IR
//   mem_req/we/addr_sel memory handshake and address source
//   alu_src, alu_op    ALU operand B source and operation class
//   reg_we, wb_sel     register write and write-back source
//   instr_retired      one-cycle commit pulse
//   fault              sticky illegal-opcode / memory-timeout flag
//   state              current state (debug)
// All outputs are forced low while rst is high so an in-flight access is
// abandoned in the very cycle reset is sampled.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       instr_retired,
  output logic       fault,
  output logic [2:0] state
);

  state_e state_q, state_d;
  logic   fault_q, fault_d;
  logic   tmr_expired;

  wire in_access = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d != state_q),
    .count_en (in_access && !mem_ready),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    ir_we         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    instr_retired = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (tmr_expired) begin
            state_d = ST_TRAP;
          end
        end
        ST_DECODE: state_d = is_legal_op(opcode) ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          case (opcode)
            OP_R: begin
              alu_op  = ALU_FUNCT;
              state_d = ST_WB;
            end
            OP_IMM, OP_LUI, OP_AUIPC: begin
              alu_src = 1'b1;
              state_d = ST_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src = 1'b1;
              state_d = ST_MEM;
            end
            OP_BRANCH: begin
              alu_op        = ALU_BR;
              pc_we         = 1'b1;
              pc_sel        = branch_taken ? PC_IMM : PC_PLUS4;
              instr_retired = 1'b1;
              state_d       = ST_FETCH;
            end
            OP_JALR: begin
              // rs1 + imm is the jump target consumed in WB
              alu_src = 1'b1;
              state_d = ST_WB;
            end
            OP_JAL:  state_d = ST_WB;
            default: state_d = ST_TRAP;
          endcase
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              pc_we         = 1'b1;
              instr_retired = 1'b1;
              state_d       = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (tmr_expired) begin
            state_d = ST_TRAP;
          end
        end
        ST_WB: begin
          reg_we        = 1'b1;
          pc_we         = 1'b1;
          instr_retired = 1'b1;
          wb_sel        = (opcode == OP_LOAD) ? WB_MEM :
                          (opcode == OP_JAL || opcode == OP_JALR) ? WB_PC4 : WB_ALU;
          pc_sel        = (opcode == OP_JAL)  ? PC_IMM :
                          (opcode == OP_JALR) ? PC_ALU : PC_PLUS4;
          state_d       = ST_FETCH;
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_TRAP;
      endcase
    end
  end

  assign fault_d = fault_q || (state_d == ST_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q && !rst;
  assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MEM_TIMEOUT=4). Each cycle: inputs are
// applied 1ns after the rising edge, outputs are compared 1ns later.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       pc_we, ir_we, mem_req, mem_we, mem_addr_sel, alu_src;
  logic       reg_we, instr_retired, fault;
  logic [1:0] pc_sel, alu_op, wb_sel;
  logic [2:0] state;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_we(pc_we), .pc_sel(pc_sel),
    .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .alu_src(alu_src), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .instr_retired(instr_retired),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ADD = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BAD = 7'b1111111;

  task automatic cyc(input logic r, input logic [6:0] op, input logic rdy, input logic bt);
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = rdy; branch_taken = bt;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output vector: {state,mreq,masel,mwe,irwe,asrc,aop,rwe,wbsel,pcwe,pcsel,ret,flt}
  task automatic ex(input string tag, input logic [2:0] st, input logic mreq,
                    input logic masel, input logic mwe, input logic irwe,
                    input logic asrc, input logic [1:0] aop, input logic rwe,
                    input logic [1:0] wbs, input logic pcwe, input logic [1:0] pcs,
                    input logic ret, input logic flt);
    logic [17:0] o, e;
    o = {state, mem_req, mem_addr_sel, mem_we, ir_we, alu_src, alu_op, reg_we,
         wb_sel, pc_we, pc_sel, instr_retired, fault};
    e = {st, mreq, masel, mwe, irwe, asrc, aop, rwe, wbs, pcwe, pcs, ret, flt};
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  initial begin
    // reset
    cyc(1, 7'd0, 0, 0); ex("rst0", 0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(1, 7'd0, 1, 0); ex("rst1", 0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);

    // add, zero-wait memory: states 0,1,2,4
    cyc(0, ADD, 1, 0); ex("add_f", 0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, ADD, 1, 0); ex("add_d", 1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, ADD, 1, 0); ex("add_e", 2, 0,0,0,0, 0,2, 0,0, 0,0, 0,0);
    cyc(0, ADD, 1, 0); ex("add_w", 4, 0,0,0,0, 0,0, 1,0, 1,0, 1,0);

    // lw with 3 wait cycles in MEM: 8 cycles total
    cyc(0, ADD, 1, 0); ex("lw_f",  0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, LW,  1, 0); ex("lw_d",  1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, LW,  1, 0); ex("lw_e",  2, 0,0,0,0, 1,0, 0,0, 0,0, 0,0);
    cyc(0, LW,  0, 0); ex("lw_m1", 3, 1,1,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, LW,  0, 0); ex("lw_m2", 3, 1,1,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, LW,  0, 0); ex("lw_m3", 3, 1,1,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, LW,  1, 0); ex("lw_m4", 3, 1,1,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, LW,  1, 0); ex("lw_w",  4, 0,0,0,0, 0,0, 1,1, 1,0, 1,0);

    // beq taken then not taken: 3 cycles each, no reg_we
    cyc(0, LW,  1, 0); ex("bt_f", 0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, BEQ, 1, 1); ex("bt_d", 1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, BEQ, 1, 1); ex("bt_e", 2, 0,0,0,0, 0,1, 0,0, 1,1, 1,0);
    cyc(0, BEQ, 1, 0); ex("bn_f", 0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, BEQ, 1, 0); ex("bn_d", 1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, BEQ, 1, 0); ex("bn_e", 2, 0,0,0,0, 0,1, 0,0, 1,0, 1,0);

    // sw with reset during the MEM wait
    cyc(0, BEQ, 1, 0); ex("swr_f",  0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  1, 0); ex("swr_d",  1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  1, 0); ex("swr_e",  2, 0,0,0,0, 1,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  0, 0); ex("swr_m1", 3, 1,1,1,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  0, 0); ex("swr_m2", 3, 1,1,1,0, 0,0, 0,0, 0,0, 0,0);
    cyc(1, SW,  1, 0); ex("swr_rst", 0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);

    // release into FETCH with mem_ready stuck low: TRAP on 5th cycle
    cyc(0, SW, 0, 0); ex("to_w1", 0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW, 0, 0); ex("to_w2", 0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW, 0, 0); ex("to_w3", 0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW, 0, 0); ex("to_w4", 0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW, 1, 0); ex("to_trap", 5, 0,0,0,0, 0,0, 0,0, 0,0, 0,1);

    // rerun: mem_ready on wait cycle 4 is accepted; then illegal opcode
    cyc(1, SW,  0, 0); ex("rr_rst", 0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  0, 0); ex("rr_w1",  0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  0, 0); ex("rr_w2",  0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  0, 0); ex("rr_w3",  0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  1, 0); ex("rr_w4",  0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, BAD, 1, 0); ex("ill_d",  1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, BAD, 1, i[0]);
      ex($sformatf("ill_trap%0d", i), 5, 0,0,0,0, 0,0, 0,0, 0,0, 0,1);
    end
    cyc(1, BAD, 1, 0); ex("ill_rst", 0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);

    // jalr then jal: PC source and link write-back
    cyc(0, BAD,  1, 0); ex("jr_f", 0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, JALR, 1, 0); ex("jr_d", 1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, JALR, 1, 0); chk("jr_e_state", 32'(state), 32'd2);
    cyc(0, JALR, 1, 0); ex("jr_w", 4, 0,0,0,0, 0,0, 1,2, 1,2, 1,0);
    cyc(0, JALR, 1, 0); ex("j_f",  0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, JAL,  1, 0); ex("j_d",  1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, JAL,  1, 0); chk("j_e_state", 32'(state), 32'd2);
    cyc(0, JAL,  1, 0); ex("j_w",  4, 0,0,0,0, 0,0, 1,2, 1,1, 1,0);

    // sw zero-wait: commits in MEM, 4 cycles
    cyc(0, JAL, 1, 0); ex("sw_f", 0, 1,0,0,1, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  1, 0); ex("sw_d", 1, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  1, 0); ex("sw_e", 2, 0,0,0,0, 1,0, 0,0, 0,0, 0,0);
    cyc(0, SW,  1, 0); ex("sw_m", 3, 1,1,1,0, 0,0, 0,0, 1,0, 1,0);
    cyc(0, SW,  0, 0); ex("sw_next", 0, 1,0,0,0, 0,0, 0,0, 0,0, 0,0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
